mem_byte_ctrl: RTL and testbench
================================

# mem_byte_ctrl

Memory-access stage of the RISC-V pipeline: consumes the load/store request the execute stage produces (address, direction, size, signedness, store data, destination register) and performs it over an 8-bit single-port RAM, one byte per cycle, little-endian. It stalls the pipeline while busy and returns sign- or zero-extended load data toward write-back. Non-memory instructions pass through combinationally with zero added latency.

## Interface
Parameters:
- ADDR_W, 32, request/RAM address width
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_addr_i  in  ADDR_W  byte address of access
- req_wr_i  in  1  0 load, 1 store
- req_cnf_i  in  2  0 no memory access, 1 byte, 2 half, 3 word
- req_signed_i  in  1  1 sign-extend load, 0 zero-extend; ignored for stores and word
- req_wdata_i  in  DATA_W  store data / ALU result for pass-through
- wd_i  in  5  destination register
- wreg_i  in  1  register write enable
- ram_a_o  out  ADDR_W  RAM byte address
- ram_wr_o  out  1  RAM write strobe
- ram_dout_o  out  8  RAM write byte
- ram_din_i  in  8  RAM read byte, valid one cycle after address
- wd_o  out  5  destination register to write-back
- wreg_o  out  1  write enable to write-back
- wdata_o  out  DATA_W  result to write-back
- mem_stall_o  out  1  holds upstream request stable while high
- misalign_o  out  1  misaligned-access pulse (MEM_ALIGN_CHK_EN only; else tied 0)

## Operation
- States: IDLE, RD, WR, DONE; byte counter cnt (2 bits); byte buffer buf[3:0]; latched request copy.
- IDLE, req_cnf_i=0: wd_o=wd_i, wreg_o=wreg_i, wdata_o=req_wdata_i, mem_stall_o=0, ram_wr_o=0.
- IDLE, req_cnf_i!=0: latch request; byte 0 issued this cycle (ram_a_o=req_addr_i, ram_wr_o=req_wr_i, ram_dout_o=req_wdata_i[7:0]); cnt<=1; next state RD or WR (DONE if store byte).
- N = 1/2/4 for cnf 1/2/3. Byte k address = latched addr + k, modulo 2^ADDR_W (0xFFFFFFFF+1 -> 0).
- RD: issue byte cnt while cnt<N; capture ram_din_i into buf[k] one cycle after byte k issued; after last capture go DONE.
- WR: ram_dout_o = wdata byte cnt, ram_wr_o=1; after byte N-1 go DONE.
- DONE: mem_stall_o=0, ram_wr_o=0; load: wdata_o = extended buf, wd_o/wreg_o from latched copy; store: wreg_o=0, wdata_o=0. Next state IDLE.
- Extension: byte {24{s&b0[7]},b0}; half {16{s&b1[7]},b1,b0}; word b3..b0.
- Request inputs changing while not IDLE are ignored; latched copy is authoritative.
- ram_a_o holds last address and ram_wr_o=0 in DONE and idle pass-through.

## Timing
- mem_stall_o high in every non-DONE cycle of a memory access, including the IDLE accept cycle.
- Load: total N+2 cycles (LB 3, LH 4, LW 6); stall high N+1 cycles.
- Store: total N+1 cycles (SB 2, SH 3, SW 5); stall high N cycles.
- Back-to-back: new request accepted in the IDLE cycle immediately after DONE.
- Reset: while rst high all outputs 0 (mem_stall_o 0, ram_wr_o 0); state<=IDLE, cnt, buf, latch <=0. Reset mid-store aborts; bytes already written are not restored.

## Configuration
- MEM_ALIGN_CHK_EN defined: half at addr[0]!=0 or word at addr[1:0]!=0 -> no RAM access, ram_wr_o stays 0, misalign_o pulses 1 cycle in accept cycle, one-cycle stall, then DONE with wreg_o=0, wdata_o=0.
- Undefined: misaligned accesses proceed byte-wise as normal; misalign_o tied 0.

## Structure
- Shared package mem_pkg: cnf encodings MEM_NONE/MEM_B/MEM_H/MEM_W, state enum, byte-count function of cnf.
- One sub-module: mem_load_ext (combinational extension of buf by size and signedness).

## Test plan
- cnf=0, req_wdata_i=0x1234, wd=5, wreg=1 -> same-cycle wdata_o=0x1234, wd_o=5, stall 0, ram_wr_o 0.
- SW addr 0x100 data 0xDEADBEEF -> writes EF,BE,AD,DE to 0x100..0x103 in 4 consecutive cycles, stall 4 cycles, wreg_o=0.
- LB addr 0x100 with RAM 0x80, signed -> wdata_o=0xFFFFFF80 in cycle 3; LBU -> 0x00000080.
- LH at 0xFFFFFFFF (check disabled) -> bytes from 0xFFFFFFFF and 0x00000000; with MEM_ALIGN_CHK_EN -> misalign_o pulse, no RAM access, wreg_o=0.
- rst asserted during 2nd byte of SW -> next cycle IDLE, ram_wr_o 0, only byte 0 written; subsequent LW completes normally.
- LW followed immediately by SB -> SB accepted in cycle after LW DONE; upstream change during LW stall has no effect.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and size helpers for the memory-access stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_pkg;

    // Access size encodings carried on req_cnf_i
    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_B    = 2'd1;
    localparam logic [1:0] MEM_H    = 2'd2;
    localparam logic [1:0] MEM_W    = 2'd3;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // Number of bytes moved for a given size encoding (0 for non-memory ops)
    function automatic logic [2:0] cnf_bytes(input logic [1:0] cnf);
        case (cnf)
            MEM_B:   return 3'd1;
            MEM_H:   return 3'd2;
            MEM_W:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Index of the final byte of an access (N-1); 0 for non-memory ops
    function automatic logic [1:0] cnf_last(input logic [1:0] cnf);
        logic [2:0] n;
        n = cnf_bytes(cnf);
        if (n == 3'd0) begin
            return 2'd0;
        end
        n = n - 3'd1;
        return n[1:0];
    endfunction

    // Natural-alignment test: halves on even addresses, words on multiples of 4
    function automatic logic cnf_misaligned(input logic [1:0] cnf, input logic [1:0] addr_lo);
        case (cnf)
            MEM_H:   return addr_lo[0];
            MEM_W:   return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Widens the little-endian load buffer to register width by size and signedness.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module mem_load_ext
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0][7:0]    buf_i,
    input  logic [1:0]         cnf_i,
    input  logic               signed_i,
    output logic [DATA_W-1:0]  data_o
);

    logic [31:0] w_ext;
    logic        w_sb;
    logic        w_sh;

    // Sign bit of the top loaded byte, squashed for unsigned loads
    assign w_sb = signed_i & buf_i[0][7];
    assign w_sh = signed_i & buf_i[1][7];

    // Select byte / half / word view of the buffer
    always_comb begin
        w_ext = 32'h0000_0000;
        case (cnf_i)
            MEM_B:   w_ext = {{24{w_sb}}, buf_i[0]};
            MEM_H:   w_ext = {{16{w_sh}}, buf_i[1], buf_i[0]};
            MEM_W:   w_ext = {buf_i[3], buf_i[2], buf_i[1], buf_i[0]};
            default: w_ext = 32'h0000_0000;
        endcase
    end

    assign data_o = DATA_W'(w_ext);

endmodule

// File: rtl/mem_byte_ctrl.sv
// RISC-V memory stage: byte-serial load/store over an 8-bit single-port RAM, little-endian.
// Latency: loads N+2 cycles, stores N+1 (N = 1/2/4); non-memory ops pass through in 0 cycles.
// Backpressure: mem_stall_o holds the upstream request while busy. Optional: MEM_ALIGN_CHK_EN.
module mem_byte_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_wr_i,
    input  logic [1:0]        req_cnf_i,
    input  logic              req_signed_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              mem_stall_o,
    output logic              misalign_o
);

    // FSM state and byte sequencing
    mem_state_t        r_state;
    logic [1:0]        r_cnt;
    logic              r_all_iss;
    logic [3:0][7:0]   r_buf;
    logic              r_mis;
    logic [ADDR_W-1:0] r_last_a;

    // Latched copy of the accepted request; authoritative once accepted
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic [1:0]        r_cnf;
    logic              r_signed;
    logic [DATA_W-1:0] r_wdata;
    logic [4:0]        r_wd;
    logic              r_wreg;

    // Combinational helpers
    logic              w_accept;
    logic              w_misalign;
    logic [1:0]        w_req_last;
    logic [1:0]        w_lat_last;
    logic [1:0]        w_cap_idx;
    logic [ADDR_W-1:0] w_issue_a;
    logic [DATA_W-1:0] w_ext;

    // Output drive before the reset gate
    logic [ADDR_W-1:0] w_ram_a;
    logic              w_ram_wr;
    logic [7:0]        w_ram_dout;
    logic [4:0]        w_wd;
    logic              w_wreg;
    logic [DATA_W-1:0] w_wdata;
    logic              w_stall;

    assign w_accept   = (r_state == IDLE) && (req_cnf_i != MEM_NONE);
    assign w_req_last = cnf_last(req_cnf_i);
    assign w_lat_last = cnf_last(r_cnf);
    // RAM data returns one cycle late, so the byte captured now is the one issued last cycle
    assign w_cap_idx  = r_cnt - 2'd1;
    // Byte address wraps modulo 2^ADDR_W
    assign w_issue_a  = r_addr + ADDR_W'(r_cnt);

`ifdef MEM_ALIGN_CHK_EN
    assign w_misalign = w_accept && cnf_misaligned(req_cnf_i, req_addr_i[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    mem_load_ext #(
        .DATA_W   (DATA_W)
    ) u_load_ext (
        .buf_i    (r_buf),
        .cnf_i    (r_cnf),
        .signed_i (r_signed),
        .data_o   (w_ext)
    );

    // Drive RAM and write-back outputs from the current state; everything forced low in reset
    always_comb begin
        w_ram_a    = r_last_a;
        w_ram_wr   = 1'b0;
        w_ram_dout = 8'h00;
        w_wd       = 5'd0;
        w_wreg     = 1'b0;
        w_wdata    = '0;
        w_stall    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_cnf_i == MEM_NONE) begin
                    w_wd    = wd_i;
                    w_wreg  = wreg_i;
                    w_wdata = req_wdata_i;
                end else begin
                    w_stall = 1'b1;
                    if (!w_misalign) begin
                        w_ram_a    = req_addr_i;
                        w_ram_wr   = req_wr_i;
                        w_ram_dout = req_wdata_i[7:0];
                    end
                end
            end
            RD: begin
                w_stall = 1'b1;
                if (!r_all_iss) begin
                    w_ram_a = w_issue_a;
                end
            end
            WR: begin
                w_stall    = 1'b1;
                w_ram_a    = w_issue_a;
                w_ram_wr   = 1'b1;
                w_ram_dout = r_wdata[{r_cnt, 3'b000} +: 8];
            end
            DONE: begin
                w_wd = r_wd;
                if (!r_wr && !r_mis) begin
                    w_wreg  = r_wreg;
                    w_wdata = w_ext;
                end
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
        if (rst) begin
            w_ram_a    = '0;
            w_ram_wr   = 1'b0;
            w_ram_dout = 8'h00;
            w_wd       = 5'd0;
            w_wreg     = 1'b0;
            w_wdata    = '0;
            w_stall    = 1'b0;
        end
    end

    assign ram_a_o     = w_ram_a;
    assign ram_wr_o    = w_ram_wr;
    assign ram_dout_o  = w_ram_dout;
    assign wd_o        = w_wd;
    assign wreg_o      = w_wreg;
    assign wdata_o     = w_wdata;
    assign mem_stall_o = w_stall;
    assign misalign_o  = rst ? 1'b0 : w_misalign;

    // Remember the last presented address so idle and DONE cycles hold it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_a <= '0;
        end else begin
            r_last_a <= w_ram_a;
        end
    end

    // Access sequencer: accept, step bytes, collect load data, hand off in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 2'd0;
            r_all_iss <= 1'b0;
            r_buf     <= '0;
            r_mis     <= 1'b0;
            r_addr    <= '0;
            r_wr      <= 1'b0;
            r_cnf     <= MEM_NONE;
            r_signed  <= 1'b0;
            r_wdata   <= '0;
            r_wd      <= 5'd0;
            r_wreg    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr    <= req_addr_i;
                        r_wr      <= req_wr_i;
                        r_cnf     <= req_cnf_i;
                        r_signed  <= req_signed_i;
                        r_wdata   <= req_wdata_i;
                        r_wd      <= wd_i;
                        r_wreg    <= wreg_i;
                        r_cnt     <= 2'd1;
                        r_all_iss <= (w_req_last == 2'd0);
                        r_mis     <= w_misalign;
                        if (w_misalign) begin
                            r_state <= DONE;
                        end else if (req_wr_i) begin
                            r_state <= (w_req_last == 2'd0) ? DONE : WR;
                        end else begin
                            r_state <= RD;
                        end
                    end
                end
                RD: begin
                    r_buf[w_cap_idx] <= ram_din_i;
                    if (r_all_iss) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt     <= r_cnt + 2'd1;
                        r_all_iss <= (r_cnt == w_lat_last);
                    end
                end
                WR: begin
                    if (r_cnt == w_lat_last) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_mis   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Scoreboard bench for mem_byte_ctrl: stimulus queues expected RAM writes and
// write-back results, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_byte_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_addr_i;
    logic        req_wr_i;
    logic [1:0]  req_cnf_i;
    logic        req_signed_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        mem_stall_o;
    logic        misalign_o;

    always #5 clk = ~clk;

    mem_byte_ctrl #(
        .ADDR_W       (32),
        .DATA_W       (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_addr_i   (req_addr_i),
        .req_wr_i     (req_wr_i),
        .req_cnf_i    (req_cnf_i),
        .req_signed_i (req_signed_i),
        .req_wdata_i  (req_wdata_i),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .ram_a_o      (ram_a_o),
        .ram_wr_o     (ram_wr_o),
        .ram_dout_o   (ram_dout_o),
        .ram_din_i    (ram_din_i),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .wdata_o      (wdata_o),
        .mem_stall_o  (mem_stall_o),
        .misalign_o   (misalign_o)
    );

    // Scoreboard queues
    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] data;
    } wb_exp_t;
    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_exp_t;

    wb_exp_t wbq[$];
    string   wbnq[$];
    wr_exp_t wq[$];

    int checks   = 0;
    int failures = 0;
    int mis_seen = 0;
    bit mon_en   = 1'b0;
    bit loaded   = 1'b0;

    // RAM model: 2 KiB window on the low address bits, registered read
    logic [7:0] mem [0:2047];
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
            mem[11'h300] <= 8'h80;
            mem[11'h7FF] <= 8'h34;   // 0xFFFFFFFF
            mem[11'h000] <= 8'h92;   // 0x00000000
            mem[11'h201] <= 8'h01;
            mem[11'h202] <= 8'h02;
            mem[11'h203] <= 8'h03;
            loaded <= 1'b1;
        end else if (ram_wr_o) begin
            mem[ram_a_o[10:0]] <= ram_dout_o;
        end
        ram_din_i <= mem[ram_a_o[10:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
        wr_exp_t e;
        e.a = a;
        e.d = d;
        wq.push_back(e);
    endtask

    // Monitor: every RAM write and every non-stalled cycle is matched against the queues
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (misalign_o === 1'b1) mis_seen++;
            if (ram_wr_o === 1'b1) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ram_write: addr 0x%0h data 0x%0h, expected none", ram_a_o, ram_dout_o);
                end else begin
                    wr_exp_t e;
                    e = wq.pop_front();
                    check("ram_addr", ram_a_o, e.a);
                    check("ram_data", {24'h0, ram_dout_o}, {24'h0, e.d});
                end
            end
            if (mem_stall_o === 1'b0) begin
                if (wbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wb: wreg %0b data 0x%0h, expected none", wreg_o, wdata_o);
                end else begin
                    wb_exp_t e;
                    string   n;
                    e = wbq.pop_front();
                    n = wbnq.pop_front();
                    check({n, "_wreg"}, {31'h0, wreg_o}, {31'h0, e.wreg});
                    check({n, "_wdata"}, wdata_o, e.data);
                    if (e.wreg) check({n, "_wd"}, {27'h0, wd_o}, {27'h0, e.wd});
                end
            end
        end
    end

    // Drives one request (caller sits just after a posedge) and counts stall cycles
    task automatic issue(input string name, input logic [31:0] a, input logic wr,
                         input logic [1:0] cnf, input logic sg, input logic [31:0] wdat,
                         input logic [4:0] wd, input logic wreg,
                         input logic [31:0] exp_dat, input logic exp_wreg,
                         input int exp_stall, input bit garble);
        wb_exp_t e;
        int stalls;
        int guard;
        req_addr_i   = a;
        req_wr_i     = wr;
        req_cnf_i    = cnf;
        req_signed_i = sg;
        req_wdata_i  = wdat;
        wd_i         = wd;
        wreg_i       = wreg;
        e.wd   = wd;
        e.wreg = exp_wreg;
        e.data = exp_dat;
        wbq.push_back(e);
        wbnq.push_back(name);
        stalls = 0;
        guard  = 0;
        @(negedge clk);
        while (mem_stall_o === 1'b1 && guard < 16) begin
            stalls++;
            guard++;
            @(posedge clk);
            #1;
            if (garble) begin
                req_addr_i   = $urandom;
                req_wr_i     = 1'($urandom_range(0, 1));
                req_cnf_i    = 2'($urandom_range(0, 3));
                req_signed_i = 1'($urandom_range(0, 1));
                req_wdata_i  = $urandom;
                wd_i         = 5'($urandom_range(0, 31));
                wreg_i       = 1'b1;
            end
            @(negedge clk);
        end
        check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        req_addr_i   = 32'h0000_0104;
        req_wr_i     = 1'b1;
        req_cnf_i    = 2'd3;
        req_signed_i = 1'b1;
        req_wdata_i  = 32'hFFFF_FFFF;
        wd_i         = 5'd31;
        wreg_i       = 1'b1;

        // Reset state with a live request on the inputs
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'h0, mem_stall_o}, 32'h0);
        check("rst_ram_wr", {31'h0, ram_wr_o}, 32'h0);
        check("rst_wreg", {31'h0, wreg_o}, 32'h0);
        check("rst_wdata", wdata_o, 32'h0);
        check("rst_ram_a", ram_a_o, 32'h0);
        check("rst_misalign", {31'h0, misalign_o}, 32'h0);

        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Pass-through
        issue("pass", 32'h0, 1'b0, 2'd0, 1'b0, 32'h1234, 5'd5, 1'b1, 32'h1234, 1'b1, 0, 1'b0);

        // SW 0x100 <- 0xDEADBEEF
        push_wr(32'h100, 8'hEF); push_wr(32'h101, 8'hBE);
        push_wr(32'h102, 8'hAD); push_wr(32'h103, 8'hDE);
        issue("sw", 32'h100, 1'b1, 2'd3, 1'b0, 32'hDEADBEEF, 5'd7, 1'b1, 32'h0, 1'b0, 4, 1'b0);

        // Byte loads of 0x80, signed and unsigned
        issue("lb", 32'h300, 1'b0, 2'd1, 1'b1, 32'h0, 5'd8, 1'b1, 32'hFFFF_FF80, 1'b1, 2, 1'b0);
        issue("lbu", 32'h300, 1'b0, 2'd1, 1'b0, 32'h0, 5'd9, 1'b1, 32'h0000_0080, 1'b1, 2, 1'b0);
        issue("lb_be", 32'h101, 1'b0, 2'd1, 1'b1, 32'h0, 5'd10, 1'b1, 32'hFFFF_FFBE, 1'b1, 2, 1'b0);

        // Half loads
        issue("lh", 32'h100, 1'b0, 2'd2, 1'b1, 32'h0, 5'd11, 1'b1, 32'hFFFF_BEEF, 1'b1, 3, 1'b0);
        issue("lhu", 32'h102, 1'b0, 2'd2, 1'b0, 32'h0, 5'd12, 1'b1, 32'h0000_DEAD, 1'b1, 3, 1'b0);

`ifdef MEM_ALIGN_CHK_EN
        issue("lh_wrap", 32'hFFFF_FFFF, 1'b0, 2'd2, 1'b1, 32'h0, 5'd13, 1'b1, 32'h0, 1'b0, 1, 1'b0);
        issue("sh_mis", 32'h401, 1'b1, 2'd2, 1'b0, 32'h0000_CAFE, 5'd14, 1'b0, 32'h0, 1'b0, 1, 1'b0);
`else
        issue("lh_wrap", 32'hFFFF_FFFF, 1'b0, 2'd2, 1'b1, 32'h0, 5'd13, 1'b1, 32'hFFFF_9234, 1'b1, 3, 1'b0);
        push_wr(32'h401, 8'hFE); push_wr(32'h402, 8'hCA);
        issue("sh_mis", 32'h401, 1'b1, 2'd2, 1'b0, 32'h0000_CAFE, 5'd14, 1'b0, 32'h0, 1'b0, 2, 1'b0);
`endif

        // LW with upstream churn during stall, then SB back-to-back
        issue("lw", 32'h100, 1'b0, 2'd3, 1'b0, 32'h0, 5'd15, 1'b1, 32'hDEAD_BEEF, 1'b1, 5, 1'b1);
        push_wr(32'h500, 8'h77);
        issue("sb", 32'h500, 1'b1, 2'd1, 1'b0, 32'h1122_3377, 5'd16, 1'b1, 32'h0, 1'b0, 1, 1'b0);
        issue("pass2", 32'h0, 1'b0, 2'd0, 1'b0, 32'hCAFE_F00D, 5'd3, 1'b1, 32'hCAFE_F00D, 1'b1, 0, 1'b0);

        // Reset during the second byte of a SW: only byte 0 lands
        push_wr(32'h200, 8'h44);
        req_addr_i   = 32'h200;
        req_wr_i     = 1'b1;
        req_cnf_i    = 2'd3;
        req_signed_i = 1'b0;
        req_wdata_i  = 32'h1122_3344;
        wd_i         = 5'd0;
        wreg_i       = 1'b0;
        @(negedge clk);
        check("sw_abort_accept_stall", {31'h0, mem_stall_o}, 32'h1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_cnf_i = 2'd0;
        @(negedge clk);
        check("sw_abort_ram_wr", {31'h0, ram_wr_o}, 32'h0);
        check("sw_abort_stall", {31'h0, mem_stall_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue("lw_after_rst", 32'h200, 1'b0, 2'd3, 1'b1, 32'h0, 5'd17, 1'b1, 32'h0302_0144, 1'b1, 5, 1'b0);

        // Drain
        mon_en      = 1'b0;
        req_cnf_i   = 2'd0;
        wreg_i      = 1'b0;
        req_wdata_i = 32'h0;
        repeat (2) @(posedge clk);
        check("pending_writes", 32'(wq.size()), 32'h0);
        check("pending_wb", 32'(wbq.size()), 32'h0);
`ifdef MEM_ALIGN_CHK_EN
        check("misalign_pulses", 32'(mis_seen), 32'd2);
`else
        check("misalign_pulses", 32'(mis_seen), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
